// File: rtl/dcd_scan_ctrl_if.sv
// Decision channel between the scan controller and the state list:
// a one-hot decision with value and level, qualified by valid and closed by ack.
interface dcd_scan_ctrl_if #(
    parameter int NUM_VARS  = 32,
    parameter int WIDTH     = 3,
    parameter int WIDTH_LVL = 16
);
    logic                 dcd_valid_o;
    logic [NUM_VARS-1:0]  dcd_index_o;
    logic [WIDTH-1:0]     dcd_value_o;
    logic [WIDTH_LVL-1:0] dcd_lvl_o;
    logic                 dcd_ack_i;

    modport master (
        output dcd_valid_o,
        output dcd_index_o,
        output dcd_value_o,
        output dcd_lvl_o,
        input  dcd_ack_i
    );

    modport slave (
        input  dcd_valid_o,
        input  dcd_index_o,
        input  dcd_value_o,
        input  dcd_lvl_o,
        output dcd_ack_i
    );
endinterface

// File: rtl/dcd_scan_ctrl.sv
// Decision scheduler: scans a bin one segment per cycle for the lowest free variable
// and offers it as a decision. Define DCD_POSITIVE_FIRST_EN to decide true instead of false.
module dcd_scan_ctrl #(
    parameter int NUM_VARS  = 32,
    parameter int WIDTH     = 3,
    parameter int SEG       = 8,
    parameter int WIDTH_LVL = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [NUM_VARS*WIDTH-1:0] value_i,
    input  logic [WIDTH_LVL-1:0]      cur_lvl_i,
    output logic                      busy_o,
    output logic                      all_assigned_o,
    dcd_scan_ctrl_if.master           dcd
);

    localparam int NUM_SEGS = NUM_VARS / SEG;
    localparam int SEG_W    = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NUM_SEGS - 1);

`ifdef DCD_POSITIVE_FIRST_EN
    localparam logic [WIDTH-1:0] DCD_VALUE = WIDTH'(3'b010);
`else
    localparam logic [WIDTH-1:0] DCD_VALUE = WIDTH'(3'b001);
`endif

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WAIT_ACK,
        DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [SEG_W-1:0]     seg_cnt_reg, seg_cnt_next;
    logic [NUM_VARS-1:0]  index_reg, index_next;
    logic [WIDTH-1:0]     value_reg, value_next;
    logic [WIDTH_LVL-1:0] lvl_reg, lvl_next;

    logic [NUM_VARS-1:0]  free_vec;
    logic [NUM_VARS-1:0]  flag_bits_unused;
    logic [SEG-1:0]       seg_free [NUM_SEGS];
    logic [SEG-1:0]       cur_free;
    logic [SEG-1:0]       cur_lowest;
    logic                 seg_found;
    logic [NUM_VARS-1:0]  pick_index;
    logic [WIDTH_LVL-1:0] lvl_sat;

    // Freeness looks only at the two value bits; the implied flag and any
    // further bits play no part in selection.
    generate
        for (genvar gi = 0; gi < NUM_VARS; gi++) begin : g_free
            assign free_vec[gi] = (value_i[gi*WIDTH +: 2] == 2'b00);
            if (WIDTH > 2) begin : g_flags
                assign flag_bits_unused[gi] = ^value_i[gi*WIDTH+2 +: WIDTH-2];
            end else begin : g_no_flags
                assign flag_bits_unused[gi] = 1'b0;
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NUM_SEGS; gi++) begin : g_seg
            assign seg_free[gi] = free_vec[gi*SEG +: SEG];
        end
    endgenerate

    assign cur_free   = seg_free[seg_cnt_reg];
    // Two's-complement trick isolates the lowest set bit of the segment.
    assign cur_lowest = cur_free & (~cur_free + SEG'(1));
    assign seg_found  = |cur_free;
    assign pick_index = NUM_VARS'(cur_lowest) << (SEG * int'(seg_cnt_reg));

    assign lvl_sat = (cur_lvl_i == '1) ? cur_lvl_i : cur_lvl_i + WIDTH_LVL'(1);

    always_comb begin
        state_next   = state_reg;
        seg_cnt_next = seg_cnt_reg;
        index_next   = index_reg;
        value_next   = value_reg;
        lvl_next     = lvl_reg;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    lvl_next     = lvl_sat;
                    seg_cnt_next = '0;
                    state_next   = SCAN;
                end
            end
            SCAN: begin
                if (seg_found) begin
                    index_next = pick_index;
                    value_next = DCD_VALUE;
                    state_next = WAIT_ACK;
                end else if (seg_cnt_reg == LAST_SEG) begin
                    state_next = DONE;
                end else begin
                    seg_cnt_next = seg_cnt_reg + SEG_W'(1);
                end
            end
            WAIT_ACK: begin
                if (dcd.dcd_ack_i) begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            seg_cnt_reg <= '0;
            index_reg   <= '0;
            value_reg   <= '0;
            lvl_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            seg_cnt_reg <= seg_cnt_next;
            index_reg   <= index_next;
            value_reg   <= value_next;
            lvl_reg     <= lvl_next;
        end
    end

    // Status outputs are pure decodes of the state register.
    assign busy_o         = (state_reg != IDLE);
    assign all_assigned_o = (state_reg == DONE);
    assign dcd.dcd_valid_o = (state_reg == WAIT_ACK);
    assign dcd.dcd_index_o = index_reg;
    assign dcd.dcd_value_o = value_reg;
    assign dcd.dcd_lvl_o   = lvl_reg;

endmodule

// File: doc/dcd_scan_ctrl.md
# dcd_scan_ctrl

Sequential decision scheduler for the state-list decision path. It scans a bin's variable value vector in fixed-size segments, one segment per cycle, and selects the lowest-indexed free variable. It then issues a one-hot decision with its assigned value and new decision level to the state list through a valid/ack handshake. If every variable is assigned, it reports that instead, so the bin controller can move to the next bin.

## Interface
Parameters:
- NUM_VARS, 32, variables per bin; must be a multiple of SEG
- WIDTH, 3, bits per variable value; [1:0] 00 = free, 01 = false, 10 = true; bit 2 = implied flag
- SEG, 8, variables examined per scan cycle
- WIDTH_LVL, 16, decision-level width

Ports (clk, rst_n: one clock; reset is synchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  pulse; begin a scan (honoured only in IDLE)
- value_i  in  NUM_VARS*WIDTH  variable values, var 0 in LSBs; held stable while busy_o
- cur_lvl_i  in  WIDTH_LVL  current decision level
- busy_o  out  1  high in SCAN, WAIT_ACK, DONE
- dcd_valid_o  out  1  decision available
- dcd_index_o  out  NUM_VARS  one-hot selected variable
- dcd_value_o  out  WIDTH  value to write for the selected variable
- dcd_lvl_o  out  WIDTH_LVL  level of the decision
- dcd_ack_i  in  1  state list accepted the decision
- all_assigned_o  out  1  one-cycle pulse: no free variable in the bin

## Operation
- FSM states: IDLE, SCAN, WAIT_ACK, DONE.
- IDLE:
  - On start_i, latch the level into dcd_lvl_o as cur_lvl_i+1, saturating at all-ones.
  - Clear the segment counter and go to SCAN.
- SCAN:
  - Segment counter seg_cnt covers 0..NUM_VARS/SEG-1.
  - Each cycle, find the lowest var j in segment seg_cnt with value[1:0]==00.
  - If found: register dcd_index_o with bit seg_cnt*SEG+j set and all other bits clear, set dcd_value_o, go to WAIT_ACK.
  - If not found and this is not the last segment: increment seg_cnt.
  - If not found in the last segment: go to DONE.
  - Implied flag (bit 2) is ignored for freeness.
- WAIT_ACK:
  - dcd_valid_o is high, and dcd_index_o, dcd_value_o and dcd_lvl_o are held constant.
  - On dcd_ack_i high, go to IDLE.
- DONE: all_assigned_o is high for this single cycle, then go to IDLE.
- dcd_value_o: 3'b001 (false, not implied) by default; see Configuration.
- start_i outside IDLE is ignored, including start_i together with ack in WAIT_ACK. dcd_ack_i outside WAIT_ACK is ignored.
- Reset values:
  - state IDLE; seg_cnt 0
  - dcd_valid_o 0, dcd_index_o 0, dcd_value_o 0, dcd_lvl_o 0
  - busy_o 0, all_assigned_o 0
- rst_n low in any state, including mid-scan or mid-handshake: everything returns to reset values on that edge. A pending decision is dropped with no ack required.

## Timing
- start_i sampled high at edge t: SCAN of segment k is evaluated in cycle t+1+k.
- Free var found in segment k: dcd_valid_o high from t+2+k.
- Minimum latency, free var in segment 0: valid 2 cycles after start.
- dcd_ack_i sampled high at edge a: dcd_valid_o and busy_o low from a+1. A new start_i is accepted at a+1 at the earliest.
- Ack in the same cycle valid first rises: legal; handshake completes on that edge.
- No free var: all_assigned_o high in cycle t+1+NUM_VARS/SEG, and busy_o falls the following cycle.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- DCD_POSITIVE_FIRST_EN defined: decisions assign true, dcd_value_o = 3'b010.
- DCD_POSITIVE_FIRST_EN undefined: decisions assign false, dcd_value_o = 3'b001.
- Nothing else changes.

## Test plan
- Var 0 free, others 01, cur_lvl_i=5; start at t, ack at t+2 -> valid at t+2 only, dcd_index_o=32'h1, dcd_value_o=3'b001, dcd_lvl_o=6, busy_o low at t+3.
- Only var 19 free (segment 2, NUM_VARS=32, SEG=8) -> valid at t+4, dcd_index_o=32'h0008_0000. Delay ack 5 cycles -> outputs held stable throughout.
- All vars 01/10, and a var with value 3'b100 (implied flag, low bits free) -> that var is selected. Then all vars with low bits nonzero -> all_assigned_o one pulse at t+5, no dcd_valid_o.
- cur_lvl_i=16'hFFFF -> dcd_lvl_o=16'hFFFF. start_i pulsed during SCAN/WAIT_ACK -> ignored. Spurious ack in IDLE -> no effect.
- rst_n low during SCAN and again during WAIT_ACK -> all outputs at reset values next edge. A following start scans from segment 0.
- Build with DCD_POSITIVE_FIRST_EN, var 7 free -> dcd_value_o=3'b010, dcd_index_o=32'h80.
